mac_serial: RTL

Parametrised, sequential unsigned multiply-accumulate unit for the MAC datapath; successor to the fixed 8-bit combinational adder. Accepts one operand pair per transaction over a valid/ready handshake, multiplies by shift-and-add over WIDTH cycles, then adds the product into a running accumulator. Flags accumulator wrap-around with a sticky overflow bit and supports synchronous clearing of the accumulator.

---
 rtl/mac_serial.sv | 101 ++++++++++
 1 files changed

// File: rtl/mac_serial.sv
// Sequential unsigned multiply-accumulate: shift-and-add multiply over WIDTH
// cycles, then add the product into a wrapping accumulator with sticky overflow.
module mac_serial #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 2*WIDTH+4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 acc_clear,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 out_valid,
  output logic                 overflow,
  output logic                 busy
);

  localparam int PW = 2*WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, MUL, ACC} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [PW-1:0]        mcand;
  logic [PW-1:0]        prod;
  logic [WIDTH-1:0]     mplier;
  logic [CW-1:0]        cnt;
  logic                 accept;
  logic                 last_bit;
  logic [ACC_WIDTH:0]   sum;

  // Handshake: an operand pair transfers on a rising edge where in_valid and
  // in_ready are both high; in_ready is high only in IDLE, so a held in_valid
  // is never accepted twice for the same operation.
  assign in_ready = (state == IDLE);
  assign busy     = ~in_ready;
  assign accept   = in_valid && in_ready;
  assign last_bit = (cnt == CW'(WIDTH-1));
  assign sum      = {1'b0, acc_out} + {{(ACC_WIDTH+1-PW){1'b0}}, prod};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = MUL;
      MUL:     if (last_bit) state_nxt = ACC;
      ACC:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand     <= '0;
      mplier    <= '0;
      prod      <= '0;
      cnt       <= '0;
      acc_out   <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (acc_clear) begin
            acc_out  <= '0;
            overflow <= 1'b0;
          end
          if (accept) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            prod   <= '0;
            cnt    <= '0;
          end
        end
        MUL: begin
          // Multiplicand shifts left as multiplier shifts right, so bit i of b
          // always meets a << i at the LSB position.
          if (mplier[0]) prod <= prod + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
        end
        ACC: begin
          acc_out   <= sum[ACC_WIDTH-1:0];
          if (sum[ACC_WIDTH]) overflow <= 1'b1;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
